// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine panel arbiter.
package vend_pkg;

  // Vending core state as reported on vm_state
  typedef enum logic [1:0] {
    CORE_IDLE    = 2'd0,
    CORE_DELIVER = 2'd1,
    CORE_CHANGE  = 2'd2
  } core_state_e;

  // Arbiter session states
  typedef enum logic [2:0] {
    ST_ARB,
    ST_OPEN,
    ST_CHK,
    ST_VEND,
    ST_REL
  } arb_state_e;

  // Legal coin strobe values
  localparam logic [7:0] COIN_NONE = 8'd0;
  localparam logic [7:0] COIN_10   = 8'd10;
  localparam logic [7:0] COIN_20   = 8'd20;
  localparam logic [7:0] COIN_50   = 8'd50;
  localparam logic [7:0] COIN_100  = 8'd100;
  localparam logic [7:0] COIN_200  = 8'd200;

  // Product prices
  localparam logic [7:0] PRICE_WATER = 8'd30;
  localparam logic [7:0] PRICE_SODA  = 8'd50;

  // Button codes
  localparam logic [1:0] BTN_NONE  = 2'd0;
  localparam logic [1:0] BTN_WATER = 2'd1;
  localparam logic [1:0] BTN_SODA  = 2'd2;

endpackage

// File: rtl/vend_rr_pick.sv
// Two-way round-robin picker: on a tie the panel that did not own last wins.
module vend_rr_pick (
  input  logic [1:0] req_i,   // bit0 = A, bit1 = B
  input  logic       last_i,  // 0 = A owned last, 1 = B owned last
  output logic [1:0] pick_o   // one-hot winner, 0 when no request
);

  // Single requests pass through; ties go to the non-last owner
  always_comb begin
    pick_o = req_i;
    if (&req_i) begin
      pick_o = last_i ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/vend_panel_arbiter.sv
// Session arbiter sharing one vending core between front panels A and B.
// Optional idle-release timer enabled by defining VEND_ARB_TIMEOUT_EN.
module vend_panel_arbiter
  import vend_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] coin_a,
  input  logic [7:0] coin_b,
  input  logic [1:0] btn_a,
  input  logic [1:0] btn_b,
  input  logic       done_a,
  input  logic       done_b,
  input  logic [1:0] vm_state,
  input  logic [7:0] vm_credit,
  output logic [7:0] vm_coin,
  output logic [1:0] vm_button,
  output logic [1:0] grant,
  output logic       busy,
  output logic       orphan
);

  if (IDLE_TIMEOUT < 2) begin : g_bad_timeout
    $error("vend_panel_arbiter: IDLE_TIMEOUT must be at least 2");
  end

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [7:0] coin_q, coin_d;
  logic [1:0] btn_q, btn_d;
  logic       last_q, last_d;
  logic       chk_q, chk_d;

  logic [1:0] pick;
  logic [7:0] own_coin;
  logic [1:0] own_btn;
  logic       own_done;
  logic       owner_act;
  logic [1:0] fwd_btn;
  logic       tmo;

  vend_rr_pick u_pick (
    .req_i  ({req_b, req_a}),
    .last_i (last_q),
    .pick_o (pick)
  );

  // Owner input selection; the non-owner panel is never looked at
  always_comb begin
    own_coin = grant_q[1] ? coin_b : coin_a;
    own_btn  = grant_q[1] ? btn_b  : btn_a;
    own_done = grant_q[1] ? done_b : done_a;
  end

  assign owner_act = (own_coin != '0) || (own_btn != BTN_NONE);
  // Coin wins over a simultaneous button; the customer has to press again
  assign fwd_btn   = (own_coin != '0) ? BTN_NONE : own_btn;

`ifdef VEND_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(IDLE_TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_TIMEOUT - 1);

  logic [TW-1:0] idle_q, idle_d;

  // Idle counter: held clear outside OPEN (so it starts at 0 on entry) and on owner activity
  always_comb begin
    if ((state_q != ST_OPEN) || owner_act) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end

  assign tmo = (state_q == ST_OPEN) && !owner_act && (idle_q == IDLE_LAST);
`else
  assign tmo = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_ARB;
    else     state_q <= state_d;
  end

  // Next-state logic; chk_q marks the second CHK cycle
  always_comb begin
    state_d = state_q;
    chk_d   = 1'b0;
    unique case (state_q)
      ST_ARB:  if (pick != 2'b00) state_d = ST_OPEN;
      ST_OPEN: begin
        if (fwd_btn != BTN_NONE) state_d = ST_CHK;
        else if (own_done)       state_d = ST_REL;
        else if (tmo)            state_d = ST_REL;
      end
      ST_CHK: begin
        if (chk_q) state_d = (vm_state == CORE_IDLE) ? ST_OPEN : ST_VEND;
        else       chk_d   = 1'b1;
      end
      ST_VEND: begin
        if (vm_state == CORE_IDLE) state_d = (vm_credit == '0) ? ST_REL : ST_OPEN;
      end
      ST_REL:  state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Output logic; grant drops and the pointer moves on the edge entering REL
  always_comb begin
    grant_d = grant_q;
    coin_d  = '0;
    btn_d   = BTN_NONE;
    last_d  = last_q;
    unique case (state_q)
      ST_ARB:  grant_d = pick;
      ST_OPEN: begin
        coin_d = own_coin;
        btn_d  = fwd_btn;
      end
      default: ;
    endcase
    if ((state_q != ST_REL) && (state_d == ST_REL)) begin
      grant_d = '0;
      last_d  = grant_q[1];
    end
  end

  // Registered outputs and session bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      coin_q  <= '0;
      btn_q   <= BTN_NONE;
      last_q  <= 1'b1;
      chk_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      coin_q  <= coin_d;
      btn_q   <= btn_d;
      last_q  <= last_d;
      chk_q   <= chk_d;
    end
  end

  assign vm_coin   = coin_q;
  assign vm_button = btn_q;
  assign grant     = grant_q;
  assign busy      = |grant_q;
  assign orphan    = (state_q == ST_REL) && (vm_credit != '0);

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Self-checking bench for vend_panel_arbiter (timer checks follow VEND_ARB_TIMEOUT_EN).
module tb_vend_panel_arbiter;
  import vend_pkg::*;

  localparam int unsigned TO = 4;
`ifdef VEND_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] coin_a = '0, coin_b = '0;
  logic [1:0] btn_a = '0, btn_b = '0;
  logic       done_a = 1'b0, done_b = 1'b0;
  logic [1:0] vm_state = '0;
  logic [7:0] vm_credit = '0;
  logic [7:0] vm_coin;
  logic [1:0] vm_button;
  logic [1:0] grant;
  logic       busy;
  logic       orphan;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vend_panel_arbiter #(.IDLE_TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .coin_a    (coin_a),
    .coin_b    (coin_b),
    .btn_a     (btn_a),
    .btn_b     (btn_b),
    .done_a    (done_a),
    .done_b    (done_b),
    .vm_state  (vm_state),
    .vm_credit (vm_credit),
    .vm_coin   (vm_coin),
    .vm_button (vm_button),
    .grant     (grant),
    .busy      (busy),
    .orphan    (orphan)
  );

  // Session-level reference model: who owns the core and what phase the session is in
  string m_phase = "arb";
  int    m_owner = -1;   // -1 none, 0 A, 1 B
  int    m_last  = 1;
  int    m_coin  = 0;
  int    m_btn   = 0;
  int    m_chk_left = 0;
  int    m_idle  = 0;

  function automatic void m_release();
    m_last  = m_owner;
    m_owner = -1;
    m_phase = "rel";
  endfunction

  function automatic void model_step();
    int oc, ob;
    bit od;
    if (rst) begin
      m_phase = "arb"; m_owner = -1; m_last = 1; m_coin = 0; m_btn = 0;
      m_chk_left = 0; m_idle = 0;
      return;
    end
    if (m_phase == "arb") begin
      m_coin = 0; m_btn = 0;
      if (req_a && req_b) m_owner = 1 - m_last;
      else if (req_a)     m_owner = 0;
      else if (req_b)     m_owner = 1;
      if (m_owner >= 0) begin m_phase = "open"; m_idle = 0; end
    end else if (m_phase == "open") begin
      oc = (m_owner == 1) ? int'(coin_b) : int'(coin_a);
      ob = (m_owner == 1) ? int'(btn_b)  : int'(btn_a);
      od = (m_owner == 1) ? done_b : done_a;
      m_coin = oc;
      m_btn  = (oc != 0) ? 0 : ob;
      if (m_btn != 0) begin
        m_phase = "check"; m_chk_left = 1;
      end else if (od) begin
        m_release();
      end else if (TMO_EN && oc == 0 && ob == 0 && m_idle == int'(TO) - 1) begin
        m_release();
      end
      m_idle = (oc != 0 || ob != 0) ? 0 : m_idle + 1;
    end else if (m_phase == "check") begin
      m_coin = 0; m_btn = 0;
      if (m_chk_left > 0) m_chk_left--;
      else if (vm_state == 2'd0) begin m_phase = "open"; m_idle = 0; end
      else m_phase = "vend";
    end else if (m_phase == "vend") begin
      m_coin = 0; m_btn = 0;
      if (vm_state == 2'd0) begin
        if (vm_credit == 0) m_release();
        else begin m_phase = "open"; m_idle = 0; end
      end
    end else begin
      m_coin = 0; m_btn = 0;
      m_phase = "arb";
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: model and DUT both take the edge, then outputs are compared 1 ns later
  task automatic tick();
    logic [1:0] eg;
    @(posedge clk);
    model_step();
    #1;
    eg = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    check("grant", {6'b0, grant}, {6'b0, eg});
    check("busy", {7'b0, busy}, {7'b0, m_owner >= 0});
    check("vm_coin", vm_coin, 8'(m_coin));
    check("vm_button", {6'b0, vm_button}, 8'(m_btn));
    check("orphan", {7'b0, orphan}, {7'b0, (m_phase == "rel") && (vm_credit != 0)});
  endtask

  task automatic idle_inputs();
    req_a = 0; req_b = 0; coin_a = '0; coin_b = '0; btn_a = '0; btn_b = '0;
    done_a = 0; done_b = 0; vm_state = '0; vm_credit = '0;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick(); tick();
    rst = 0;
  endtask

  logic [7:0] coins [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd20, 8'd50, 8'd100, 8'd200};

  initial begin
    // Reset state
    do_reset();
    check("rst_grant", {6'b0, grant}, 8'd0);
    check("rst_vm_coin", vm_coin, 8'd0);

    // Single request from A, two 20 coins, water, deliver then change
    req_a = 1; tick();
    check("a_grant", {6'b0, grant}, 8'd1);
    req_a = 0; coin_a = COIN_20; tick();
    check("a_coin1", vm_coin, 8'd20);
    vm_credit = 8'd20; tick();
    vm_credit = 8'd40; coin_a = '0; btn_a = BTN_WATER; tick();
    check("a_btn", {6'b0, vm_button}, 8'd1);
    btn_a = '0; vm_state = 2'd1; vm_credit = 8'd10; tick();
    tick();
    check("a_vend_grant", {6'b0, grant}, 8'd1);
    vm_state = 2'd2; vm_credit = 8'd0; tick();
    vm_state = 2'd0; tick();
    check("a_rel_busy", {7'b0, busy}, 8'd0);
    check("a_rel_orphan", {7'b0, orphan}, 8'd0);
    tick();

    // Tie after reset goes to A, then B, then A again
    do_reset();
    req_a = 1; req_b = 1; tick();
    check("tie1", {6'b0, grant}, 8'd1);
    done_a = 1; tick();
    done_a = 0; tick(); tick();
    check("tie2", {6'b0, grant}, 8'd2);
    done_b = 1; tick();
    done_b = 0; tick(); tick();
    check("tie3", {6'b0, grant}, 8'd1);

    // Owner B: coin and button together, then soda alone into a vend
    do_reset();
    req_b = 1; tick();
    req_b = 0; coin_b = COIN_50; btn_b = BTN_SODA; coin_a = COIN_100; btn_a = BTN_WATER; tick();
    check("b_coin50", vm_coin, 8'd50);
    check("b_btn0", {6'b0, vm_button}, 8'd0);
    vm_credit = 8'd50; coin_b = '0; coin_a = '0; btn_a = '0; tick();
    check("b_btn2", {6'b0, vm_button}, 8'd2);
    btn_b = '0; vm_state = 2'd1; vm_credit = 8'd0; tick(); tick();
    // Reset during VEND clears everything on that edge
    rst = 1; tick();
    check("vend_rst_grant", {6'b0, grant}, 8'd0);
    check("vend_rst_coin", vm_coin, 8'd0);
    rst = 0; vm_state = '0; tick();

    // Insufficient credit: CHK returns to OPEN with the grant kept
    do_reset();
    req_a = 1; tick();
    req_a = 0; vm_credit = 8'd30; btn_a = BTN_SODA; tick();
    btn_a = '0; tick(); tick();
    check("short_grant", {6'b0, grant}, 8'd1);
    coin_a = COIN_10; tick();
    check("short_reopen", vm_coin, 8'd10);
    coin_a = '0; done_a = 1; tick();
    check("short_orphan", {7'b0, orphan}, 8'd1);
    done_a = 0; tick();

    // Idle release
    do_reset();
    req_a = 1; tick();
    req_a = 0; coin_a = COIN_20; tick();
    coin_a = '0; vm_credit = 8'd20;
    if (TMO_EN) begin
      tick(); tick(); tick();
      check("tmo_hold", {6'b0, grant}, 8'd1);
      tick();
      check("tmo_rel", {6'b0, grant}, 8'd0);
      check("tmo_orphan", {7'b0, orphan}, 8'd1);
      tick();
    end else begin
      for (int i = 0; i < 100; i++) tick();
      check("no_tmo", {6'b0, grant}, 8'd1);
    end

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 249) == 0);
      req_a    = $urandom_range(0, 1) == 1;
      req_b    = $urandom_range(0, 1) == 1;
      coin_a   = coins[$urandom_range(0, 8)];
      coin_b   = coins[$urandom_range(0, 8)];
      btn_a    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      btn_b    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      done_a   = ($urandom_range(0, 15) == 0);
      done_b   = ($urandom_range(0, 15) == 0);
      vm_state = ($urandom_range(0, 3) < 2) ? 2'd0 : 2'($urandom_range(1, 2));
      vm_credit = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
